iir_lpf_biquad: RTL and testbench

IIR_LPF_BIQUAD -- requirements
Module: iir_lpf_biquad

---
 rtl/iir_lpf_biquad.sv | 139 +++++++++++++
 tb/tb_iir_lpf_biquad.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_lpf_biquad.sv
// Direct Form I biquad low-pass filter with a stb/ack handshake and one shared 32x16 multiplier.
// Define IIR_LPF_SATURATE_EN to clamp the output to 32 bits instead of wrapping it.
module iir_lpf_biquad #(
    parameter logic signed [15:0] B0   = 16'sd1024,
    parameter logic signed [15:0] B1   = 16'sd2048,
    parameter logic signed [15:0] B2   = 16'sd1024,
    parameter logic signed [15:0] A1   = -16'sd16384,
    parameter logic signed [15:0] A2   = 16'sd4096,
    parameter int                 FRAC = 14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    typedef enum logic [1:0] {S_GET, S_MAC, S_ROUND, S_PUT} state_t;

    localparam logic signed [63:0] HALF = 64'sd1 <<< (FRAC - 1);

    state_t             r_state;
    state_t             w_next;
    logic signed [31:0] r_x, r_x1, r_x2, r_y1, r_y2;
    logic signed [63:0] r_acc;
    logic [2:0]         r_cnt;
    logic               r_input_a_ack;
    logic [31:0]        r_output_z;
    logic               r_output_z_stb;

    logic signed [31:0] w_mulA;
    logic signed [15:0] w_mulB;
    logic               w_sub;
    logic signed [47:0] w_prod;
    logic signed [63:0] w_prodExt;
    logic signed [31:0] w_y;

    assign input_a_ack  = r_input_a_ack;
    assign output_z     = r_output_z;
    assign output_z_stb = r_output_z_stb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_GET;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_GET:   if (r_input_a_ack && input_a_stb) w_next = S_MAC;
            S_MAC:   if (r_cnt == 3'd4) w_next = S_ROUND;
            S_ROUND: w_next = S_PUT;
            S_PUT:   if (output_z_ack) w_next = S_GET;
            default: w_next = S_GET;
        endcase
    end

    // Term counter walks B0, B1, B2 (added) then A1, A2 (subtracted) through the one multiplier.
    always_comb begin
        w_mulA = '0;
        w_mulB = '0;
        w_sub  = 1'b0;
        case (r_cnt)
            3'd0: begin w_mulA = r_x;  w_mulB = B0; end
            3'd1: begin w_mulA = r_x1; w_mulB = B1; end
            3'd2: begin w_mulA = r_x2; w_mulB = B2; end
            3'd3: begin w_mulA = r_y1; w_mulB = A1; w_sub = 1'b1; end
            3'd4: begin w_mulA = r_y2; w_mulB = A2; w_sub = 1'b1; end
            default: ;
        endcase
    end

    assign w_prod    = 48'(w_mulA) * 48'(w_mulB);
    assign w_prodExt = {{16{w_prod[47]}}, w_prod};

`ifdef IIR_LPF_SATURATE_EN
    logic signed [63:0] w_rounded;
    assign w_rounded = (r_acc + HALF) >>> FRAC;

    always_comb begin
        if (w_rounded > 64'sd2147483647)       w_y = 32'sh7FFFFFFF;
        else if (w_rounded < -64'sd2147483648) w_y = 32'sh80000000;
        else                                   w_y = w_rounded[31:0];
    end
`else
    assign w_y = 32'((r_acc + HALF) >>> FRAC);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x            <= '0;
            r_x1           <= '0;
            r_x2           <= '0;
            r_y1           <= '0;
            r_y2           <= '0;
            r_acc          <= '0;
            r_cnt          <= '0;
            r_input_a_ack  <= 1'b0;
            r_output_z     <= '0;
            r_output_z_stb <= 1'b0;
        end else begin
            case (r_state)
                S_GET: begin
                    if (r_input_a_ack && input_a_stb) begin
                        r_x           <= input_a;
                        r_acc         <= '0;
                        r_cnt         <= '0;
                        r_input_a_ack <= 1'b0;
                    end else begin
                        r_input_a_ack <= 1'b1;
                    end
                end
                S_MAC: begin
                    r_acc <= w_sub ? (r_acc - w_prodExt) : (r_acc + w_prodExt);
                    r_cnt <= r_cnt + 3'd1;
                end
                S_ROUND: begin
                    r_output_z     <= w_y;
                    r_output_z_stb <= 1'b1;
                    r_x2           <= r_x1;
                    r_x1           <= r_x;
                    r_y2           <= r_y1;
                    r_y1           <= w_y;
                end
                S_PUT: begin
                    if (output_z_ack) begin
                        r_output_z_stb <= 1'b0;
                        r_input_a_ack  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iir_lpf_biquad.sv
// Scoreboarded directed bench for iir_lpf_biquad: default filter plus a B0-only instance for overflow.
module tb_iir_lpf_biquad;

    localparam int FRAC = 14;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] input_a = '0;
    logic        input_a_stb = 1'b0;
    logic        input_a_ack;
    logic [31:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack = 1'b0;

    logic [31:0] oIn = '0;
    logic        oStb = 1'b0;
    logic        oAck;
    logic [31:0] oZ;
    logic        oZStb;
    logic        oZAck = 1'b0;

    int nCompared = 0;
    int nMismatched = 0;
    int cyc = 0;

    logic [31:0] expQ[$];
    longint mx1 = 0, mx2 = 0, my1 = 0, my2 = 0;

    iir_lpf_biquad dut (
        .clk(clk), .rst(rst),
        .input_a(input_a), .input_a_stb(input_a_stb), .input_a_ack(input_a_ack),
        .output_z(output_z), .output_z_stb(output_z_stb), .output_z_ack(output_z_ack)
    );

    iir_lpf_biquad #(.B0(16'sd32767), .B1(16'sd0), .B2(16'sd0), .A1(16'sd0), .A2(16'sd0), .FRAC(14)) dutOvf (
        .clk(clk), .rst(rst),
        .input_a(oIn), .input_a_stb(oStb), .input_a_ack(oAck),
        .output_z(oZ), .output_z_stb(oZStb), .output_z_ack(oZAck)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] refFilter(input longint c0, c1, c2, d1, d2,
                                              input longint x0, x1, x2, y1, y2);
        longint acc, r;
        acc = c0 * x0 + c1 * x1 + c2 * x2 - d1 * y1 - d2 * y2;
        r = (acc + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
`ifdef IIR_LPF_SATURATE_EN
        if (r > 64'sd2147483647)       r = 64'sd2147483647;
        else if (r < -64'sd2147483648) r = -64'sd2147483648;
`endif
        return r[31:0];
    endfunction

    task automatic modelReset();
        mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
        expQ.delete();
    endtask

    task automatic modelPush(input logic [31:0] x);
        logic [31:0] y;
        longint xs;
        xs = longint'($signed(x));
        y = refFilter(1024, 2048, 1024, -16384, 4096, xs, mx1, mx2, my1, my2);
        expQ.push_back(y);
        mx2 = mx1; mx1 = xs;
        my2 = my1; my1 = longint'($signed(y));
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed 0x%08h (%0d) expected 0x%08h (%0d)",
                   tag, obs, $signed(obs), exp, $signed(exp));
        end
    endtask

    // Leaves the bench at the negedge just after the accepting edge.
    task automatic applyStimulus(input logic [31:0] x, output int acceptCyc);
        int waited = 0;
        acceptCyc = -100;
        @(negedge clk);
        input_a = x;
        input_a_stb = 1'b1;
        while (!input_a_ack && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!input_a_ack) begin
            check("accept_timeout", {31'b0, input_a_ack}, 32'd1);
            input_a_stb = 1'b0;
            return;
        end
        modelPush(x);
        @(posedge clk);
        @(negedge clk);
        acceptCyc = cyc;
        input_a_stb = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input int acceptCyc, input bit checkLat,
                               input bit doAck, output logic [31:0] obs);
        int waited = 0;
        logic [31:0] exp;
        obs = 'x;
        while (!output_z_stb && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!output_z_stb) begin
            check({tag, "_timeout"}, {31'b0, output_z_stb}, 32'd1);
            if (expQ.size() > 0) void'(expQ.pop_front());
            return;
        end
        if (expQ.size() == 0) begin
            check({tag, "_unexpected"}, 32'd0, 32'd1);
            return;
        end
        exp = expQ.pop_front();
        obs = output_z;
        check(tag, obs, exp);
        if (checkLat) check({tag, "_latency"}, 32'(cyc - acceptCyc), 32'd6);
        if (doAck) begin
            output_z_ack = 1'b1;
            @(posedge clk);
            @(negedge clk);
            output_z_ack = 1'b0;
            check({tag, "_ack_back"}, {31'b0, input_a_ack}, 32'd1);
            check({tag, "_stb_drop"}, {31'b0, output_z_stb}, 32'd0);
        end
    endtask

    task automatic resetPulse();
        @(negedge clk);
        rst = 1'b1;
        modelReset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int ac;
        int waited;
        logic [31:0] obs;
        logic [31:0] held;
        logic [31:0] vals[4];
        int outCyc[4];
        int idx, nOut;
        bit pend, sawStb;

        // Asynchronous reset takes effect before any clock edge.
        #2 rst = 1'b1;
        #2;
        check("rst_output_z", output_z, 32'd0);
        check("rst_output_z_stb", {31'b0, output_z_stb}, 32'd0);
        check("rst_input_a_ack", {31'b0, input_a_ack}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("ack_low_before_edge", {31'b0, input_a_ack}, 32'd0);
        @(negedge clk);
        check("ack_first_edge", {31'b0, input_a_ack}, 32'd1);

        // Impulse response.
        modelReset();
        applyStimulus(32'd16384, ac);
        checkOutput("impulse0", ac, 1'b1, 1'b1, obs);
        check("impulse0_const", obs, 32'd1024);
        applyStimulus(32'd0, ac);
        checkOutput("impulse1", ac, 1'b1, 1'b1, obs);
        check("impulse1_const", obs, 32'd3072);
        applyStimulus(32'd0, ac);
        checkOutput("impulse2", ac, 1'b1, 1'b1, obs);

        // Output held while downstream stalls, then async reset while in PUT.
        applyStimulus(32'd777, ac);
        checkOutput("stall", ac, 1'b1, 1'b0, obs);
        held = output_z;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_z_stable", output_z, held);
            check("stall_stb_high", {31'b0, output_z_stb}, 32'd1);
            check("stall_ack_low", {31'b0, input_a_ack}, 32'd0);
        end
        rst = 1'b1;
        modelReset();
        #1;
        check("putrst_output_z", output_z, 32'd0);
        check("putrst_stb", {31'b0, output_z_stb}, 32'd0);
        check("putrst_ack", {31'b0, input_a_ack}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset during MAC abandons the sample and clears histories.
        applyStimulus(32'd16384, ac);
        @(negedge clk);
        rst = 1'b1;
        modelReset();
        @(negedge clk);
        rst = 1'b0;
        sawStb = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (output_z_stb) sawStb = 1'b1;
        end
        check("macrst_no_output", {31'b0, sawStb}, 32'd0);
        applyStimulus(32'd16384, ac);
        checkOutput("macrst_next", ac, 1'b1, 1'b1, obs);
        check("macrst_next_const", obs, 32'd1024);

        // Step response from clean histories.
        resetPulse();
        for (int i = 0; i < 40; i++) begin
            applyStimulus(32'd1000, ac);
            checkOutput("step", ac, 1'b0, 1'b1, obs);
        end

        // Back-to-back streaming with stb and ack held high.
        vals[0] = 32'd100;
        vals[1] = 32'hFFFFFF38;
        vals[2] = 32'd300000;
        vals[3] = 32'hFFFFFE70;
        idx = 0; nOut = 0; pend = 1'b0;
        input_a = vals[0];
        input_a_stb = 1'b1;
        output_z_ack = 1'b1;
        for (int c = 0; c < 200 && nOut < 4; c++) begin
            if (output_z_stb) begin
                if (expQ.size() > 0) check("stream_value", output_z, expQ.pop_front());
                else check("stream_unexpected", 32'd0, 32'd1);
                outCyc[nOut] = cyc;
                nOut++;
            end
            if (input_a_ack && input_a_stb && idx < 4) begin
                modelPush(input_a);
                idx++;
                pend = 1'b1;
            end else if (pend) begin
                pend = 1'b0;
                if (idx < 4) input_a = vals[idx];
                else input_a_stb = 1'b0;
            end
            @(negedge clk);
        end
        input_a_stb = 1'b0;
        @(negedge clk);
        output_z_ack = 1'b0;
        check("stream_count", 32'(nOut), 32'd4);
        for (int i = 1; i < 4; i++) begin
            if (i < nOut) check("stream_spacing", 32'(outCyc[i] - outCyc[i-1]), 32'd8);
        end

        // Overflow instance: B0 = 32767 only.
        @(negedge clk);
        oIn = 32'h7FFFFFFF;
        oStb = 1'b1;
        waited = 0;
        while (!oAck && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("ovf_accept", {31'b0, oAck}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        oStb = 1'b0;
        waited = 0;
        while (!oZStb && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("ovf_stb", {31'b0, oZStb}, 32'd1);
        check("ovf_value", oZ, refFilter(32767, 0, 0, 0, 0, 64'sd2147483647, 0, 0, 0, 0));
        oZAck = 1'b1;
        @(posedge clk);
        @(negedge clk);
        oZAck = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
